// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Host byte link, CPU fetch address, instruction-memory write
//               port and loader status bundled for the imem_loader block.
// Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    // host byte link
    logic              load_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    // CPU fetch address and instruction-memory port
    logic [ADDR_W-1:0] pc_a;
    logic [ADDR_W-1:0] imem_a;
    logic              imem_we;
    logic [31:0]       imem_wd;
    // status
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    // loader side
    modport slave (
        input  load_start, rx_data, rx_valid, pc_a,
        output rx_ready, imem_a, imem_we, imem_wd, cpu_hold, busy, done, error
    );

    // host / system side
    modport master (
        output load_start, rx_data, rx_valid, pc_a,
        input  rx_ready, imem_a, imem_we, imem_wd, cpu_hold, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot/reload controller for the instruction memory. Receives a
//               word-count header and big-endian 32-bit words over a byte
//               link, writes them from address 0 while the CPU is held, then
//               returns the memory address to the CPU fetch address.
// Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W       = 6,
    parameter int TIMEOUT      = 65535,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    imem_loader_if.slave  bus
);

    localparam int c_DEPTH  = 2 ** ADDR_W;
    localparam int c_IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value at which one more idle cycle means the timeout has expired
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
        c_IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_RUN  = 3'd3;
    localparam logic [2:0] c_ST_ERR  = 3'd4;
    localparam logic [2:0] c_ST_RESET = RUN_ON_RESET ? c_ST_RUN : c_ST_IDLE;

    // registered state
    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_waddr;
    logic [1:0]          r_bidx;
    logic [ADDR_W:0]     r_wcnt;
    logic [c_IDLE_W-1:0] r_idle;
    logic [23:0]         r_asm;
    logic                r_we;
    logic [31:0]         r_wd;
    logic                r_done;

    // next-state values
    logic [2:0]          w_state_nxt;
    logic [ADDR_W-1:0]   w_waddr_nxt;
    logic [1:0]          w_bidx_nxt;
    logic [ADDR_W:0]     w_wcnt_nxt;
    logic [c_IDLE_W-1:0] w_idle_nxt;
    logic [23:0]         w_asm_nxt;
    logic                w_we_nxt;
    logic [31:0]         w_wd_nxt;
    logic                w_done_nxt;

    logic w_in_load;
    logic w_accept;
    logic w_timeout;
    logic w_hdr_bad;
    logic w_last_write;

    // Loading states own the byte link; everything else is derived from state
    assign w_in_load    = (r_state == c_ST_HDR) || (r_state == c_ST_DATA);
    assign w_accept     = bus.rx_valid && w_in_load;
    assign w_timeout    = (TIMEOUT != 0) && w_in_load && !w_accept &&
                          (r_idle == c_IDLE_LAST);
    assign w_hdr_bad    = (bus.rx_data == 8'd0) ||
                          (int'({24'd0, bus.rx_data}) > c_DEPTH);
    // The write cycle of the final word: wcnt reaches 0 on the closing edge
    assign w_last_write = r_we && (r_wcnt == (ADDR_W + 1)'(1));

    assign bus.rx_ready = w_in_load;
    assign bus.busy     = w_in_load;
    assign bus.cpu_hold = (r_state != c_ST_RUN);
    assign bus.error    = (r_state == c_ST_ERR);
    assign bus.imem_a   = (r_state == c_ST_RUN) ? bus.pc_a : r_waddr;
    assign bus.imem_we  = r_we;
    assign bus.imem_wd  = r_wd;
    assign bus.done     = r_done;

    // State register: async reset drops any in-flight write immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_RESET;
            r_waddr <= '0;
            r_bidx  <= '0;
            r_wcnt  <= '0;
            r_idle  <= '0;
            r_asm   <= '0;
            r_we    <= 1'b0;
            r_wd    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_waddr <= w_waddr_nxt;
            r_bidx  <= w_bidx_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_idle  <= w_idle_nxt;
            r_asm   <= w_asm_nxt;
            r_we    <= w_we_nxt;
            r_wd    <= w_wd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: header check, byte assembly, write sequencing, timeout
    always_comb begin
        w_state_nxt = r_state;
        w_waddr_nxt = r_waddr;
        w_bidx_nxt  = r_bidx;
        w_wcnt_nxt  = r_wcnt;
        w_idle_nxt  = r_idle;
        w_asm_nxt   = r_asm;
        w_we_nxt    = 1'b0;
        w_wd_nxt    = r_wd;
        w_done_nxt  = 1'b0;

        if (w_in_load) begin
            w_idle_nxt = w_accept ? '0 : r_idle + c_IDLE_W'(1);
        end

        case (r_state)
            c_ST_IDLE, c_ST_RUN, c_ST_ERR: begin
                // A byte offered alongside load_start is not accepted here
                if (bus.load_start) begin
                    w_state_nxt = c_ST_HDR;
                    w_waddr_nxt = '0;
                    w_bidx_nxt  = '0;
                    w_idle_nxt  = '0;
                end
            end

            c_ST_HDR: begin
                if (w_accept) begin
                    if (w_hdr_bad) begin
                        w_state_nxt = c_ST_ERR;
                    end else begin
                        w_wcnt_nxt  = (ADDR_W + 1)'(bus.rx_data);
                        w_state_nxt = c_ST_DATA;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_ERR;
                end
            end

            c_ST_DATA: begin
                // The edge closing a write cycle advances the address/count
                if (r_we) begin
                    w_waddr_nxt = r_waddr + ADDR_W'(1);
                    w_wcnt_nxt  = r_wcnt - (ADDR_W + 1)'(1);
                end
                // Big-endian assembly; the fourth byte launches the write
                if (w_accept) begin
                    case (r_bidx)
                        2'd0:    w_asm_nxt[23:16] = bus.rx_data;
                        2'd1:    w_asm_nxt[15:8]  = bus.rx_data;
                        2'd2:    w_asm_nxt[7:0]   = bus.rx_data;
                        default: begin
                            w_we_nxt = 1'b1;
                            w_wd_nxt = {r_asm, bus.rx_data};
                        end
                    endcase
                    w_bidx_nxt = r_bidx + 2'd1;
                end
                if (w_last_write) begin
                    w_state_nxt = c_ST_RUN;
                    w_done_nxt  = 1'b1;
                    w_we_nxt    = 1'b0;
                end else if (w_timeout) begin
                    // Any partially assembled word is simply abandoned
                    w_state_nxt = c_ST_ERR;
                end
            end

            default: begin
                w_state_nxt = c_ST_RESET;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader with a memory-image
//               reference model and randomized programs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int stall_cnt = 0;

    typedef struct { int a; logic [31:0] d; } wr_t;
    wr_t         wr_q[$];
    logic [31:0] mem_dut   [DEPTH] = '{default: 32'h0};
    logic [31:0] mem_model [DEPTH];

    int                done_cnt    = 0;
    int                done_cyc    = 0;
    int                last_we_cyc = 0;
    logic              hold_at_done = 1'b1;
    logic              pend_v = 1'b0;
    logic [ADDR_W-1:0] pend_a;
    logic [31:0]       pend_d;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT     (TIMEOUT),
        .RUN_ON_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behaves as the instruction memory: a write sampled in a cycle lands at
    // the closing edge unless reset is raised before then.
    always @(negedge clk) begin
        if (pend_v && !reset) begin
            mem_dut[pend_a] = pend_d;
            wr_q.push_back('{int'(pend_a), pend_d});
        end
        pend_v = 1'b0;
        if (bus.imem_we === 1'b1 && !reset) begin
            pend_v      = 1'b1;
            pend_a      = bus.imem_a;
            pend_d      = bus.imem_wd;
            last_we_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            hold_at_done = bus.cpu_hold;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int k);
        bus.rx_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && guard < 64) begin
            stall_cnt++;
            @(negedge clk);
            guard++;
        end
        if (bus.rx_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte: rx_ready low for %0d cycles, want 1", guard);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit junk);
        bus.load_start = 1'b1;
        if (junk) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h00;
        end
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] hdr, input logic [31:0] words[$],
                            input int gap_max, input bit junk);
        logic [31:0] w;
        pulse_start(junk);
        send_byte(hdr);
        foreach (words[i]) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                gap($urandom_range(0, gap_max));
                send_byte(w[31 - 8 * b -: 8]);
            end
        end
        gap(0);
    endtask

    task automatic wait_done(input int d0, input int bound, output bit ok);
        int g = 0;
        while (done_cnt == d0 && g < bound) begin
            @(negedge clk);
            g++;
        end
        ok = (done_cnt != d0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.pc_a       = '0;
        reset          = 1'b1;
        #12;
        n_tests++;
        if ({bus.cpu_hold, bus.rx_ready, bus.imem_we, bus.done, bus.error, bus.busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: hold/rdy/we/done/err/busy=%b want 000000",
                     {bus.cpu_hold, bus.rx_ready, bus.imem_we, bus.done, bus.error, bus.busy});
        end
        n_tests++;
        if (bus.imem_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_imem_wd: got %h want 00000000", bus.imem_wd);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.pc_a = ADDR_W'(i);
            #1;
            n_tests++;
            if (bus.imem_a !== ADDR_W'(i) || bus.cpu_hold !== 1'b0 || bus.imem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL run_fetch_%0d: imem_a=%0d hold=%b we=%b want %0d 0 0",
                         i, bus.imem_a, bus.cpu_hold, bus.imem_we, i);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_rate();
        logic [31:0] words[$];
        int w0, d0, bad;
        bit ok;
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        w0 = wr_q.size();
        d0 = done_cnt;
        stall_cnt = 0;
        run_load(8'(DEPTH), words, 0, 1'b0);
        wait_done(d0, 400, ok);
        tick(3);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_done: no done pulse within bound, want one");
        end
        n_tests++;
        if (wr_q.size() - w0 != DEPTH) begin
            n_fail++;
            $display("FAIL full_write_count: got %0d want %0d", wr_q.size() - w0, DEPTH);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w0 + i >= wr_q.size()) bad++;
            else if (wr_q[w0 + i].a != i || wr_q[w0 + i].d !== words[i]) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_write_content: %0d bad writes, want 0", bad);
        end
        n_tests++;
        if (stall_cnt != 0) begin
            n_fail++;
            $display("FAIL full_no_stall: rx_ready low %0d cycles, want 0", stall_cnt);
        end
        n_tests++;
        if (done_cyc != last_we_cyc + 1 || hold_at_done !== 1'b0 || done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL full_done_timing: done_cyc=%0d last_we=%0d hold=%b pulses=%0d want %0d 0 1",
                     done_cyc, last_we_cyc, hold_at_done, done_cnt - d0, last_we_cyc + 1);
        end
        for (int i = 0; i < DEPTH; i++) mem_model[i] = words[i];
    endtask

    task automatic test_basic_load();
        logic [31:0] words[$];
        int w0, d0;
        bit ok;
        words = '{32'h28020005, 32'h10070000};
        w0 = wr_q.size();
        d0 = done_cnt;
        run_load(8'h02, words, 0, 1'b0);
        wait_done(d0, 40, ok);
        tick(3);
        n_tests++;
        if (!ok || wr_q.size() - w0 != 2) begin
            n_fail++;
            $display("FAIL basic_writes: done=%0d writes=%0d want 1 2", ok, wr_q.size() - w0);
        end else begin
            n_tests++;
            if (wr_q[w0].a != 0 || wr_q[w0].d !== 32'h28020005 ||
                wr_q[w0 + 1].a != 1 || wr_q[w0 + 1].d !== 32'h10070000) begin
                n_fail++;
                $display("FAIL basic_content: %0d:%h %0d:%h want 0:28020005 1:10070000",
                         wr_q[w0].a, wr_q[w0].d, wr_q[w0 + 1].a, wr_q[w0 + 1].d);
            end
        end
        n_tests++;
        if (done_cnt != d0 + 1 || hold_at_done !== 1'b0 || done_cyc != last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d hold=%b done_cyc=%0d want 1 0 %0d",
                     done_cnt - d0, hold_at_done, done_cyc, last_we_cyc + 1);
        end
        bus.pc_a = ADDR_W'($urandom_range(0, DEPTH - 1));
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.imem_a !== bus.pc_a) begin
            n_fail++;
            $display("FAIL basic_after: busy=%b hold=%b imem_a=%0d want 0 0 %0d",
                     bus.busy, bus.cpu_hold, bus.imem_a, bus.pc_a);
        end
        mem_model[0] = words[0];
        mem_model[1] = words[1];
        @(negedge clk);
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[2];
        int w0, d0;
        hdrs[0] = 8'h41;
        hdrs[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            w0 = wr_q.size();
            d0 = done_cnt;
            bus.pc_a = ADDR_W'(5);
            pulse_start(1'b0);
            n_tests++;
            if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL badhdr_start_%0d: error=%b busy=%b want 0 1", k, bus.error, bus.busy);
            end
            send_byte(hdrs[k]);
            gap(3);
            n_tests++;
            if ({bus.error, bus.cpu_hold, bus.busy, bus.rx_ready} !== 4'b1100 ||
                bus.imem_a !== ADDR_W'(0)) begin
                n_fail++;
                $display("FAIL badhdr_state_%0d: err/hold/busy/rdy=%b imem_a=%0d want 1100 0",
                         k, {bus.error, bus.cpu_hold, bus.busy, bus.rx_ready}, bus.imem_a);
            end
            n_tests++;
            if (wr_q.size() != w0 || done_cnt != d0) begin
                n_fail++;
                $display("FAIL badhdr_nowrite_%0d: writes=%0d done=%0d want 0 0",
                         k, wr_q.size() - w0, done_cnt - d0);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] words[$];
        int w0, d0, c0, g, bad;
        bit ok;
        w0 = wr_q.size();
        pulse_start(1'b0);
        n_tests++;
        if (bus.error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: error=%b want 0", bus.error);
        end
        send_byte(8'h01);
        send_byte(8'hAC);
        send_byte(8'h67);
        gap(0);
        c0 = cyc;
        g  = 0;
        while (bus.error !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        n_tests++;
        if (bus.error !== 1'b1 || cyc - c0 != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_latency: error=%b after %0d cycles want 1 after %0d",
                     bus.error, cyc - c0, TIMEOUT);
        end
        tick(2);
        n_tests++;
        if (wr_q.size() != w0 || bus.cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_nowrite: writes=%0d hold=%b want 0 1", wr_q.size() - w0, bus.cpu_hold);
        end
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        d0 = done_cnt;
        run_load(8'd3, words, 4, 1'b0);
        wait_done(d0, 100, ok);
        tick(3);
        for (int i = 0; i < 3; i++) mem_model[i] = words[i];
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_dut[i] !== mem_model[i]) bad++;
        n_tests++;
        if (!ok || bus.error !== 1'b0 || bad != 0 || wr_q.size() - w0 != 3) begin
            n_fail++;
            $display("FAIL timeout_reload: done=%0d error=%b bad_words=%0d writes=%0d want 1 0 0 3",
                     ok, bus.error, bad, wr_q.size() - w0);
        end
    endtask

    task automatic test_start_then_reset();
        logic [31:0] w;
        int w0;
        w  = $urandom;
        w0 = wr_q.size();
        pulse_start(1'b0);
        send_byte(8'd4);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        gap(0);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.error !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_start: busy=%b error=%b want 1 0", bus.busy, bus.error);
        end
        send_byte(w[7:0]);
        gap(0);
        n_tests++;
        if (bus.imem_we !== 1'b1 || bus.imem_a !== ADDR_W'(0) || bus.imem_wd !== w) begin
            n_fail++;
            $display("FAIL midload_ignored: we=%b a=%0d wd=%h want 1 0 %h",
                     bus.imem_we, bus.imem_a, bus.imem_wd, w);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.imem_we, bus.rx_ready, bus.cpu_hold, bus.busy, bus.done, bus.error} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: we/rdy/hold/busy/done/err=%b want 000000",
                     {bus.imem_we, bus.rx_ready, bus.cpu_hold, bus.busy, bus.done, bus.error});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(3);
        bus.pc_a = ADDR_W'($urandom_range(0, DEPTH - 1));
        #1;
        n_tests++;
        if (wr_q.size() != w0 || bus.imem_a !== bus.pc_a || mem_dut[0] !== mem_model[0]) begin
            n_fail++;
            $display("FAIL reset_dropped_write: writes=%0d imem_a=%0d mem0=%h want 0 %0d %h",
                     wr_q.size() - w0, bus.imem_a, mem_dut[0], bus.pc_a, mem_model[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random_loads();
        logic [31:0] words[$];
        int n, w0, d0, bad;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            words.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) words.push_back($urandom);
            bus.pc_a = ADDR_W'($urandom_range(0, DEPTH - 1));
            w0 = wr_q.size();
            d0 = done_cnt;
            run_load(8'(n), words, 6, 1'b1);
            wait_done(d0, 1000, ok);
            tick(3);
            for (int i = 0; i < n; i++) mem_model[i] = words[i];
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (w0 + i >= wr_q.size()) bad++;
                else if (wr_q[w0 + i].a != i || wr_q[w0 + i].d !== words[i]) bad++;
            end
            n_tests++;
            if (!ok || bad != 0 || wr_q.size() - w0 != n || done_cnt != d0 + 1) begin
                n_fail++;
                $display("FAIL rand_load_%0d: n=%0d done=%0d bad=%0d writes=%0d want 1 0 %0d",
                         it, n, ok, bad, wr_q.size() - w0, n);
            end
            bad = 0;
            for (int i = 0; i < DEPTH; i++) if (mem_dut[i] !== mem_model[i]) bad++;
            n_tests++;
            if (bad != 0 || bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_mem_%0d: bad_words=%0d error=%b hold=%b want 0 0 0",
                         it, bad, bus.error, bus.cpu_hold);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_basic_load();
        test_bad_header();
        test_timeout();
        test_start_then_reset();
        test_random_loads();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
